alu_counter_decoder: RTL and testbench

ALU_COUNTER_DECODER -- requirements
Module: alu_counter_decoder

---
 rtl/alu_pkg.sv | 11 +
 rtl/adder_4bit.sv | 17 +
 rtl/alu_counter_decoder.sv | 57 +++++
 tb/tb_alu_counter_decoder.sv | 90 +++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcode constants shared by the ALU/counter/decoder slice
package alu_pkg;
  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] NOT = 3'b010;
  localparam logic [2:0] AND = 3'b011;
  localparam logic [2:0] OR  = 3'b100;
  localparam logic [2:0] XOR = 3'b101;
  localparam logic [2:0] LT  = 3'b110;
  localparam logic [2:0] EQ  = 3'b111;
endpackage

// File: rtl/adder_4bit.sv
// adder_4bit: 4-bit add/subtract with carry-out and signed overflow
module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sub,
  output logic [3:0] sum,
  output logic       carry,
  output logic       overflow
);
  logic [3:0] bb;
  logic [4:0] s;
  assign bb = sub ? ~b : b;
  assign s = {1'b0, a} + {1'b0, bb} + {4'b0, sub};
  assign sum = s[3:0];
  assign carry = s[4];
  assign overflow = (a[3] == bb[3]) && (s[3] != a[3]);
endmodule

// File: rtl/alu_counter_decoder.sv
// alu_counter_decoder: combinational ALU, 3-bit down-counter and 3-to-8 decoder
module alu_counter_decoder
  import alu_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        alu_fnselec,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] alu_res,
  output logic              alu_zero,
  output logic              alu_overflow,
  output logic              alu_carry,
  input  logic              counter_en,
  output logic [CNT_W-1:0]  dec_counter_out,
  input  logic [2:0]        x,
  input  logic              en,
  output logic [7:0]        y_dec
);
  logic [DATA_W-1:0] sum;
  logic c, v;
  adder_4bit u_add (
    .a(alu_a),
    .b(alu_b),
    .sub(alu_fnselec != ADD),
    .sum(sum),
    .carry(c),
    .overflow(v)
  );
  always_comb begin
    alu_res = '0;
    alu_carry = 1'b0;
    alu_overflow = 1'b0;
    case (alu_fnselec)
      ADD, SUB: begin
        alu_res = sum;
        alu_carry = c;
        alu_overflow = v;
      end
      NOT: alu_res = ~alu_a;
      AND: alu_res = alu_a & alu_b;
      OR:  alu_res = alu_a | alu_b;
      XOR: alu_res = alu_a ^ alu_b;
      LT:  alu_res = {{(DATA_W-1){1'b0}}, sum[DATA_W-1] ^ v};
      EQ:  alu_res = {{(DATA_W-1){1'b0}}, alu_a == alu_b};
      default: alu_res = '0;
    endcase
  end
  assign alu_zero = alu_res == '0;
  always_ff @(posedge clk)
    if (rst) dec_counter_out <= '1;
    else if (counter_en) dec_counter_out <= dec_counter_out - 1'b1;
  assign y_dec = en ? 8'b1 << x : 8'h00;
endmodule

// File: tb/tb_alu_counter_decoder.sv
// tb_alu_counter_decoder: directed self-checking bench for alu_counter_decoder
module tb_alu_counter_decoder;
  logic clk = 1'b0;
  logic rst, counter_en, en, alu_zero, alu_overflow, alu_carry;
  logic [2:0] alu_fnselec, x, dec_counter_out;
  logic [3:0] alu_a, alu_b, alu_res;
  logic [7:0] y_dec;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  alu_counter_decoder dut (
    .clk(clk), .rst(rst), .alu_fnselec(alu_fnselec), .alu_a(alu_a), .alu_b(alu_b),
    .alu_res(alu_res), .alu_zero(alu_zero), .alu_overflow(alu_overflow), .alu_carry(alu_carry),
    .counter_en(counter_en), .dec_counter_out(dec_counter_out), .x(x), .en(en), .y_dec(y_dec)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // {fn, a, b, res, zero, overflow, carry}
  typedef struct { logic [2:0] fn; logic [3:0] a, b, r; logic z, v, c; } vec_t;
  vec_t vecs[$] = '{
    '{3'b000, 4'h7, 4'h1, 4'h8, 1'b0, 1'b1, 1'b0},
    '{3'b000, 4'hF, 4'h1, 4'h0, 1'b1, 1'b0, 1'b1},
    '{3'b001, 4'h3, 4'h3, 4'h0, 1'b1, 1'b0, 1'b1},
    '{3'b001, 4'h8, 4'h1, 4'h7, 1'b0, 1'b1, 1'b1},
    '{3'b001, 4'h1, 4'h2, 4'hF, 1'b0, 1'b0, 1'b0},
    '{3'b010, 4'h5, 4'h0, 4'hA, 1'b0, 1'b0, 1'b0},
    '{3'b011, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b0},
    '{3'b100, 4'hC, 4'h3, 4'hF, 1'b0, 1'b0, 1'b0},
    '{3'b101, 4'hF, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0},
    '{3'b110, 4'hF, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0},
    '{3'b110, 4'h1, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0},
    '{3'b110, 4'h8, 4'h7, 4'h1, 1'b0, 1'b0, 1'b0},
    '{3'b110, 4'h7, 4'h8, 4'h0, 1'b1, 1'b0, 1'b0},
    '{3'b111, 4'h6, 4'h6, 4'h1, 1'b0, 1'b0, 1'b0},
    '{3'b111, 4'h6, 4'h7, 4'h0, 1'b1, 1'b0, 1'b0}
  };
  logic [2:0] seq [8] = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
  initial begin
    rst = 1'b1; counter_en = 1'b0; en = 1'b0; x = 3'd0;
    alu_fnselec = 3'b000; alu_a = 4'h7; alu_b = 4'h1;
    tick();
    chk("reset_cnt", 32'(dec_counter_out), 32'd7);
    chk("alu_in_reset", 32'({alu_res, alu_zero, alu_overflow, alu_carry}), 32'({4'h8, 3'b010}));
    rst = 1'b0;
    foreach (vecs[i]) begin
      alu_fnselec = vecs[i].fn; alu_a = vecs[i].a; alu_b = vecs[i].b;
      #1;
      chk($sformatf("alu%0d_fn%0b", i, vecs[i].fn),
          32'({alu_res, alu_zero, alu_overflow, alu_carry}),
          32'({vecs[i].r, vecs[i].z, vecs[i].v, vecs[i].c}));
    end
    counter_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("count%0d", i), 32'(dec_counter_out), 32'(seq[i]));
    end
    tick();
    chk("count_more", 32'(dec_counter_out), 32'd6);
    counter_en = 1'b0;
    tick();
    tick();
    chk("hold", 32'(dec_counter_out), 32'd6);
    counter_en = 1'b1;
    tick();
    chk("resume", 32'(dec_counter_out), 32'd5);
    rst = 1'b1;
    tick();
    chk("rst_priority", 32'(dec_counter_out), 32'd7);
    rst = 1'b0; counter_en = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      x = 3'(i);
      #1;
      chk($sformatf("dec_x%0d", i), 32'(y_dec), 32'(8'h01 << i));
    end
    en = 1'b0; x = 3'd5;
    #1;
    chk("dec_disabled", 32'(y_dec), 32'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
